// File: rtl/hub75_pattern_gen_pkg.sv
// Shared HUB75 definitions: pattern mode codes, panel geometry helpers, the
// scale-to-BPC width rule and the stream FSM state type.
package hub75_pattern_gen_pkg;

    localparam logic [2:0] PAT_SOLID   = 3'd0;
    localparam logic [2:0] PAT_HGRAD   = 3'd1;
    localparam logic [2:0] PAT_VGRAD   = 3'd2;
    localparam logic [2:0] PAT_CHECKER = 3'd3;
    localparam logic [2:0] PAT_BARS    = 3'd4;
    localparam logic [2:0] PAT_WALK    = 3'd5;

    typedef enum logic {StIdle, StStream} state_t;

    function automatic int unsigned panel_width(input int unsigned colbits);
        return 32'd1 << colbits;
    endfunction

    function automatic int unsigned half_height(input int unsigned rowbits);
        return 32'd1 << rowbits;
    endfunction

    function automatic int unsigned panel_height(input int unsigned rowbits);
        return 32'd1 << (rowbits + 1);
    endfunction

    // Left-align a width-bit value in bpc bits: pad LSBs with zeros or drop LSBs.
    function automatic logic [31:0] scale_to_bpc(input logic [31:0] value,
                                                 input int unsigned width,
                                                 input int unsigned bpc);
        if (bpc >= width) begin
            return value << (bpc - width);
        end
        return value >> (width - bpc);
    endfunction

endpackage

// File: rtl/hub75_pattern_pixel.sv
// Combinational pattern evaluator: one {R,G,B} pixel from the latched mode,
// effective column, panel row and frame counter LSBs.
module hub75_pattern_pixel
    import hub75_pattern_gen_pkg::*;
#(
    parameter int unsigned ROWBITS = 5,
    parameter int unsigned COLBITS = 6,
    parameter int unsigned BPC     = 8
) (
    input  logic [2:0]         mode,
    input  logic [COLBITS-1:0] xe,
    input  logic [ROWBITS:0]   py,
    input  logic [COLBITS-1:0] frame_lsb,
    input  logic [3*BPC-1:0]   color,
    output logic [3*BPC-1:0]   rgb
);

    logic [BPC-1:0] hval;
    logic [BPC-1:0] vval;
    logic           chk;
    logic [2:0]     bars;

    assign hval = BPC'(scale_to_bpc(32'(xe), COLBITS, BPC));
    assign vval = BPC'(scale_to_bpc(32'(py), ROWBITS + 1, BPC));
    // Bit 3 of column and row; zero-extension keeps narrow panels legal.
    assign chk  = ((32'(xe) ^ 32'(py)) & 32'd8) != 32'd0;
    assign bars = xe[COLBITS-1 -: 3];

    always_comb begin
        rgb = '0;
        case (mode)
            PAT_SOLID:   rgb = color;
            PAT_HGRAD:   rgb = {hval, hval, hval};
            PAT_VGRAD:   rgb = {vval, vval, vval};
            PAT_CHECKER: if (chk) rgb = '1;
            PAT_BARS:    rgb = {{BPC{bars[2]}}, {BPC{bars[1]}}, {BPC{bars[0]}}};
            PAT_WALK:    if (xe == frame_lsb) rgb = '1;
            default:     rgb = '0;
        endcase
    end

endmodule

// File: rtl/hub75_pattern_gen.sv
// HUB75 test-pattern source streaming dual-row pixel pairs over valid/ready.
// Define HUB75_PATGEN_SCROLL_EN to scroll every pattern left one column per frame.
module hub75_pattern_gen
    import hub75_pattern_gen_pkg::*;
#(
    parameter int unsigned ROWBITS   = 5,
    parameter int unsigned COLBITS   = 6,
    parameter int unsigned BPC       = 8,
    parameter int unsigned FRAMEBITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           mode,
    input  logic [3*BPC-1:0]     color,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [COLBITS-1:0]   pix_x,
    output logic [ROWBITS-1:0]   pix_y,
    output logic [3*BPC-1:0]     rgb1,
    output logic [3*BPC-1:0]     rgb2,
    output logic                 pix_last,
    output logic [FRAMEBITS-1:0] frame_count
);

    localparam logic [COLBITS-1:0] XMax      = COLBITS'(panel_width(COLBITS) - 1);
    localparam logic [ROWBITS-1:0] YMax      = ROWBITS'(half_height(ROWBITS) - 1);
    localparam logic [ROWBITS:0]   RowOffset = (ROWBITS + 1)'(half_height(ROWBITS));

    state_t                 state_q, state_d;
    logic [COLBITS-1:0]     x_q, x_d;
    logic [ROWBITS-1:0]     y_q, y_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [FRAMEBITS-1:0]   fc_q, fc_d;
    logic [2:0]             mode_q, mode_d;
    logic [3*BPC-1:0]       color_q, color_d;
    logic [3*BPC-1:0]       rgb1_q, rgb1_d;
    logic [3*BPC-1:0]       rgb2_q, rgb2_d;
    logic [COLBITS-1:0]     xe_d;
    logic [ROWBITS:0]       py_top, py_bot;
    logic                   xfer;

    assign xfer = valid_q & pix_ready;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = valid_q;
        fc_d    = fc_q;
        mode_d  = mode_q;
        color_d = color_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StStream;
                    valid_d = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    mode_d  = mode;
                    color_d = color;
                end
            end
            StStream: begin
                if (xfer) begin
                    if (last_q) begin
                        fc_d = fc_q + FRAMEBITS'(1);
                        x_d  = '0;
                        y_d  = '0;
                        if (enable) begin
                            mode_d  = mode;
                            color_d = color;
                        end else begin
                            state_d = StIdle;
                            valid_d = 1'b0;
                        end
                    end else begin
                        x_d = x_q + COLBITS'(1);
                        if (x_q == XMax) y_d = y_q + ROWBITS'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        last_d = valid_d && (x_d == XMax) && (y_d == YMax);
    end

    // Pixels are evaluated on next-state coordinates so they register with them.
`ifdef HUB75_PATGEN_SCROLL_EN
    assign xe_d = x_d + fc_d[COLBITS-1:0];
`else
    assign xe_d = x_d;
`endif
    assign py_top = {1'b0, y_d};
    assign py_bot = py_top + RowOffset;

    hub75_pattern_pixel #(
        .ROWBITS (ROWBITS),
        .COLBITS (COLBITS),
        .BPC     (BPC)
    ) u_pixel_top (
        .mode      (mode_d),
        .xe        (xe_d),
        .py        (py_top),
        .frame_lsb (fc_d[COLBITS-1:0]),
        .color     (color_d),
        .rgb       (rgb1_d)
    );

    hub75_pattern_pixel #(
        .ROWBITS (ROWBITS),
        .COLBITS (COLBITS),
        .BPC     (BPC)
    ) u_pixel_bot (
        .mode      (mode_d),
        .xe        (xe_d),
        .py        (py_bot),
        .frame_lsb (fc_d[COLBITS-1:0]),
        .color     (color_d),
        .rgb       (rgb2_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            fc_q    <= '0;
            mode_q  <= '0;
            color_q <= '0;
            rgb1_q  <= '0;
            rgb2_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            fc_q    <= fc_d;
            mode_q  <= mode_d;
            color_q <= color_d;
            rgb1_q  <= rgb1_d;
            rgb2_q  <= rgb2_d;
        end
    end

    assign pix_valid   = valid_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign pix_last    = last_q;
    assign rgb1        = rgb1_q;
    assign rgb2        = rgb2_q;
    assign frame_count = fc_q;

endmodule
